var_delay_line: RTL

- Runtime-programmable delay line: data_in/valid_in appear on data_out/valid_out exactly D clock cycles later.
- D is loadable while running, unlike the fixed compile-time-depth shift_reg delay.
- Sits beside shift_reg instances in the top to re-align streams whose skew changes with operating mode.
- Circular buffer with write pointer, derived read address, fill counter and a FILL/RUN state machine.

---
 rtl/var_delay_line_pkg.sv | 25 ++
 rtl/var_delay_line_if.sv | 36 +++
 rtl/var_delay_line_mem.sv | 45 ++++
 rtl/var_delay_line.sv | 138 +++++++++++++
 4 files changed

// File: rtl/var_delay_line_pkg.sv
// Shared types and helpers for the runtime-programmable delay line.
// Holds the FILL/RUN state encoding, the delay clamp and the pointer-width helper.
package var_delay_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Requests of 0 become 1, requests beyond the buffer become the buffer depth.
  function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned max_delay);
    if (req == 0) begin
      return 1;
    end else if (req > max_delay) begin
      return max_delay;
    end else begin
      return req;
    end
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/var_delay_line_if.sv
// Stream and control bundle of var_delay_line.
// Optional clamp_err/delay_cur exist only when VAR_DELAY_CLAMP_ERR_EN is defined.
interface var_delay_line_if #(
  parameter int DATA_WIDTH  = 12,
  parameter int DELAY_WIDTH = 6
);
  logic [DELAY_WIDTH-1:0] delay_in;
  logic                   delay_load;
  logic                   valid_in;
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   valid_out;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   busy;
`ifdef VAR_DELAY_CLAMP_ERR_EN
  logic                   clamp_err;
  logic [DELAY_WIDTH-1:0] delay_cur;

  modport master (
    output delay_in, delay_load, valid_in, data_in,
    input  valid_out, data_out, busy, clamp_err, delay_cur
  );
  modport slave (
    input  delay_in, delay_load, valid_in, data_in,
    output valid_out, data_out, busy, clamp_err, delay_cur
  );
`else
  modport master (
    output delay_in, delay_load, valid_in, data_in,
    input  valid_out, data_out, busy
  );
  modport slave (
    input  delay_in, delay_load, valid_in, data_in,
    output valid_out, data_out, busy
  );
`endif
endinterface

// File: rtl/var_delay_line_mem.sv
// Circular sample store for var_delay_line: one write port, one asynchronous read port.
// The valid column is cleared by rst; data words are never reset.
module var_delay_mem #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 32,
  parameter int AW         = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         wr_addr,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      valid_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign valid_d[gi] = (wr_addr == AW'(gi)) ? wr_valid : valid_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_data_q[wr_addr] <= wr_data;
  end

  // Reads see pre-edge contents, so reading the slot being written returns the old word.
  assign rd_valid = valid_q[rd_addr];
  assign rd_data  = mem_data_q[rd_addr];

endmodule

// File: rtl/var_delay_line.sv
// Runtime-programmable delay line: samples reappear exactly D edges later, D loadable live.
// Optional macro VAR_DELAY_CLAMP_ERR_EN adds sticky clamp_err and delay_cur outputs.
module var_delay_line
  import var_delay_pkg::*;
#(
  parameter int DATA_WIDTH    = 12,
  parameter int MAX_DELAY     = 32,
  parameter int DELAY_WIDTH   = 6,
  parameter int DEFAULT_DELAY = 5
) (
  input logic            clk,
  input logic            rst,
  var_delay_line_if.slave bus
);

  localparam int                     PW       = ptr_width(MAX_DELAY);
  localparam logic [DELAY_WIDTH-1:0] MAX_D    = DELAY_WIDTH'(MAX_DELAY);
  localparam logic [PW-1:0]          LAST_PTR = PW'(MAX_DELAY - 1);

  state_e                 state_q, state_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [DELAY_WIDTH-1:0] delay_q, delay_d;
  logic [DELAY_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic                   valid_out_q, valid_out_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;

  logic [PW-1:0]          rd_addr;
  logic [DELAY_WIDTH:0]   wr_ext;
  logic [DELAY_WIDTH:0]   rd_sum;
  logic                   rd_valid;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   load_bad;

  var_delay_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MAX_DELAY),
    .AW        (PW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_addr (wr_ptr_q),
    .wr_valid(bus.valid_in),
    .wr_data (bus.data_in),
    .rd_addr (rd_addr),
    .rd_valid(rd_valid),
    .rd_data (rd_data)
  );

  // Read address trails the write pointer by D, modulo the buffer depth.
  always_comb begin
    wr_ext = (DELAY_WIDTH + 1)'(wr_ptr_q);
    if (wr_ext >= {1'b0, delay_q}) begin
      rd_sum = wr_ext - {1'b0, delay_q};
    end else begin
      rd_sum = wr_ext + (DELAY_WIDTH + 1)'(MAX_DELAY) - {1'b0, delay_q};
    end
    rd_addr = PW'(rd_sum);
  end

  assign load_bad = (bus.delay_in == '0) || (bus.delay_in > MAX_D);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    fill_cnt_d  = (fill_cnt_q == MAX_D) ? fill_cnt_q : fill_cnt_q + 1'b1;
    delay_d     = delay_q;
    data_out_d  = rd_data;
    valid_out_d = 1'b0;

    case (state_q)
      ST_FILL: begin
        // Slots older than the last load may hold stale valid bits; gate until filled.
        valid_out_d = (fill_cnt_q >= delay_q) ? rd_valid : 1'b0;
        if (fill_cnt_q == delay_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        valid_out_d = rd_valid;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    if (bus.delay_load) begin
      delay_d     = DELAY_WIDTH'(clamp_delay(32'(bus.delay_in), MAX_DELAY));
      fill_cnt_d  = DELAY_WIDTH'(1);
      state_d     = ST_FILL;
      valid_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      delay_q     <= DELAY_WIDTH'(DEFAULT_DELAY);
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      delay_q     <= delay_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign bus.valid_out = valid_out_q;
  assign bus.data_out  = data_out_q;
  assign bus.busy      = (state_q == ST_FILL);

`ifdef VAR_DELAY_CLAMP_ERR_EN
  logic clamp_err_q, clamp_err_d;

  always_comb begin
    clamp_err_d = clamp_err_q | (bus.delay_load & load_bad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clamp_err_q <= 1'b0;
    end else begin
      clamp_err_q <= clamp_err_d;
    end
  end

  assign bus.clamp_err = clamp_err_q;
  assign bus.delay_cur = delay_q;
`else
  logic unused_load_bad;
  assign unused_load_bad = load_bad;
`endif

endmodule
